// File: rtl/pattern_serializer_pkg.sv
// Shared types and default constants for the pattern serializer and the
// detector wrapper it feeds.
package pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

  localparam int unsigned DIV_DEFAULT   = 50000;
  localparam int unsigned PAT_W_DEFAULT = 20;
  localparam int unsigned LEN_W_DEFAULT = 5;

endpackage

// File: rtl/pattern_serializer_bit_tick_gen.sv
// Modulo-DIV pacing counter: one-cycle tick at terminal count while enabled;
// clear forces the count back to zero and suppresses the tick.
module bit_tick_gen
  import pattern_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clear && (cnt_q == TERM);

endmodule

// File: rtl/pattern_serializer.sv
// Paced LSB-first serializer: latches a pattern over valid/ready and emits one
// bit every DIV clocks with bit/frame/done strobes, optional looping and abort.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEFAULT,
  parameter int unsigned LEN_W = LEN_W_DEFAULT,
  parameter int unsigned DIV   = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic             loop_en,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  ser_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_clamped;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;
  logic             tick;
  logic             tick_clear;

  // Counter is held at zero outside RUN so a transfer always starts a full period.
  assign tick_clear = abort || (state_q != RUN);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .en    (state_q == RUN),
    .tick  (tick)
  );

  always_comb begin
    len_clamped = pat_len;
    if ((pat_len == '0) || (pat_len > LEN_W'(PAT_W))) begin
      len_clamped = LEN_W'(PAT_W);
    end
  end

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    len_d         = len_q;
    idx_d         = idx_q;
    bit_out_d     = bit_out_q;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    done_d        = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pat_valid) begin
            pat_d   = pat_data;
            len_d   = len_clamped;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            bit_out_d     = pat_q[idx_q];
            bit_valid_d   = 1'b1;
            frame_start_d = (idx_q == '0);
            if (idx_q == len_q - LEN_W'(1)) begin
              idx_d = '0;
              if (!loop_en) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign pat_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer at DIV=4: expected strobes (cycle,
// bit, frame_start, done) are queued at transfer time and popped on bit_valid.
module tb_pattern_serializer;

  localparam int unsigned PAT_W = 20;
  localparam int unsigned LEN_W = 5;
  localparam int unsigned DIV   = 4;

  logic             clk;
  logic             reset;
  logic [PAT_W-1:0] pat_data;
  logic [LEN_W-1:0] pat_len;
  logic             pat_valid;
  logic             pat_ready;
  logic             loop_en;
  logic             abort;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             done;
  logic             busy;

  typedef struct {
    int   cyc;
    logic b;
    logic fs;
    logic dn;
  } exp_t;

  exp_t sb_q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  pattern_serializer #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .DIV   (DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pat_data    (pat_data),
    .pat_len     (pat_len),
    .pat_valid   (pat_valid),
    .pat_ready   (pat_ready),
    .loop_en     (loop_en),
    .abort       (abort),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .done        (done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected strobes for nbits emitted bits of a len-bit pattern, looping on wrap.
  task automatic push_seq(input logic [PAT_W-1:0] d, input int len, input int t0,
                          input int nbits, input bit last_done);
    exp_t e;
    int   k;
    for (int n = 0; n < nbits; n++) begin
      k    = n % len;
      e.cyc = t0 + int'(DIV) * (n + 1);
      e.b   = d[k];
      e.fs  = (k == 0);
      e.dn  = last_done && (n == nbits - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic xfer(input logic [PAT_W-1:0] d, input logic [LEN_W-1:0] len,
                      input logic lp, output int t0);
    chk("ready_before_xfer", pat_ready, 1);
    pat_data  = d;
    pat_len   = len;
    loop_en   = lp;
    pat_valid = 1'b1;
    @(negedge clk);
    t0        = cyc;
    pat_valid = 1'b0;
    chk("busy_after_xfer", busy, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bit_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("bit_out", bit_out, e.b);
        chk("frame_start", frame_start, e.fs);
        chk("done", done, e.dn);
      end
    end else if (frame_start || done) begin
      chk("flag_without_strobe", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    pat_data  = '0;
    pat_len   = '0;
    pat_valid = 1'b0;
    loop_en   = 1'b0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pat_ready", pat_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full-length one-shot via len=0 clamp
    xfer(20'hB6C13, 5'd0, 1'b0, t0);
    push_seq(20'hB6C13, 20, t0, 20, 1'b1);
    wait_until(t0 + 79);
    chk("t1_busy_before_last", busy, 1);
    wait_until(t0 + 80);
    chk("t1_ready_after_done", pat_ready, 1);
    chk("t1_busy_after_done", busy, 0);
    repeat (3) @(negedge clk);
    chk("t1_sb_empty", sb_q.size(), 0);

    // Looping 4-bit pattern for three frames, then loop_en dropped
    xfer(20'h00009, 5'd4, 1'b1, t0);
    push_seq(20'h00009, 4, t0, 16, 1'b1);
    wait_until(t0 + 50);
    loop_en = 1'b0;
    wait_until(t0 + 63);
    chk("t2_busy_before_done", busy, 1);
    wait_until(t0 + 64);
    chk("t2_ready_after_done", pat_ready, 1);
    repeat (6) @(negedge clk);
    chk("t2_sb_empty", sb_q.size(), 0);

    // Abort two cycles before the fifth strobe
    xfer(20'h0005A, 5'd8, 1'b0, t0);
    push_seq(20'h0005A, 8, t0, 4, 1'b0);
    wait_until(t0 + 17);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_ready_after_abort", pat_ready, 1);
    chk("t3_busy_after_abort", busy, 0);
    chk("t3_bit_out_held", bit_out, 1);
    wait_until(t0 + 40);
    chk("t3_sb_empty", sb_q.size(), 0);

    // Abort together with an offer in IDLE
    pat_data  = 20'h00007;
    pat_len   = 5'd3;
    pat_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    chk("t4_busy", busy, 0);
    chk("t4_ready", pat_ready, 1);
    pat_valid = 1'b0;
    abort     = 1'b0;
    repeat (12) @(negedge clk);
    chk("t4_busy_later", busy, 0);

    // Offer while busy must be ignored
    xfer(20'h0002D, 5'd6, 1'b0, t0);
    push_seq(20'h0002D, 6, t0, 6, 1'b1);
    wait_until(t0 + 5);
    pat_data  = 20'hFFFFF;
    pat_len   = 5'd3;
    pat_valid = 1'b1;
    @(negedge clk);
    pat_valid = 1'b0;
    wait_until(t0 + 24);
    chk("t5_ready_after_done", pat_ready, 1);
    wait_until(t0 + 30);
    chk("t5_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in a strobe cycle mid-frame
    xfer(20'hA5A5E, 5'd0, 1'b0, t0);
    push_seq(20'hA5A5E, 20, t0, 2, 1'b0);
    wait_until(t0 + 8);
    chk("t6_bit_out_pre", bit_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_bit_valid", bit_valid, 0);
    chk("t6_rst_bit_out", bit_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", pat_ready, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t6_ready_after_release", pat_ready, 1);
    repeat (30) @(negedge clk);
    chk("t6_busy_later", busy, 0);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
